issue_queue: RTL
================

Name: issue_queue

Overview:
- Dual-enqueue, dual-issue in-order FIFO that sits directly downstream of instruction decode.
- Accepts up to two decoded task_t entries per cycle (TASK_0 is older than TASK_1) and holds them until the execute stage accepts them.
- Issues up to two tasks per cycle in program order and blocks the second issue when it has a RAW dependency on the first.
- FLUSH discards all queued work on branch mispredict or redirect.

Parameters:
- DEPTH, 8: number of task entries; must be a power of 2 and at least 4.
- CW, $clog2(DEPTH)+1: width of the COUNT output; derived, not overridden.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of all entries.
- ENQ_VALID_0  in  1  TASK_0 is valid.
- ENQ_VALID_1  in  1  TASK_1 is valid.
- TASK_0  in  task_t  older decoded task.
- TASK_1  in  task_t  younger decoded task.
- ENQ_READY  out  1  queue can accept two tasks this cycle.
- ISS_TASK_0  out  task_t  oldest queued task (head).
- ISS_TASK_1  out  task_t  second-oldest task (head+1).
- ISS_VALID_0  out  1  ISS_TASK_0 is issuable.
- ISS_VALID_1  out  1  ISS_TASK_1 is issuable this cycle.
- ISS_READY_0  in  1  execute slot 0 accepts.
- ISS_READY_1  in  1  execute slot 1 accepts.
- COUNT  out  CW  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage:
  - DEPTH x task_t array with head/tail pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
  - COUNT is a separate register. Array contents are not reset.
- Reset (RST_N low, async): head=0, tail=0, COUNT=0.
  - Resulting outputs: ISS_VALID_0=0, ISS_VALID_1=0, ENQ_READY=1.
  - ISS_TASK_x are don't-care while the matching valid is 0.
  - Reset asserted mid-operation discards all entries immediately.
- ENQ_READY = (DEPTH - COUNT >= 2).
  - Combinational from registered COUNT only.
  - Never depends on same-cycle dequeue; there is no enqueue/dequeue bypass.
- Enqueue, only when ENQ_READY=1:
  - n_enq = ENQ_VALID_0 + ENQ_VALID_1.
  - Valid tasks are written compacted, in order: TASK_0 first, then TASK_1, starting at tail.
  - ENQ_VALID_1 alone writes TASK_1 at tail.
  - tail advances by n_enq.
  - When ENQ_READY=0 nothing is written; upstream holds its tasks (all-or-nothing, no partial pair).
- Issue slot 0: ISS_VALID_0 = (COUNT >= 1). fire_0 = ISS_VALID_0 & ISS_READY_0.
- RAW hazard between the two head entries: set when all of the following hold:
  - entry0.rd_used = 1 and entry0.rd_addr != 0, and
  - either entry1.rs1_used with entry1.rs1_addr == entry0.rd_addr, or entry1.rs2_used with entry1.rs2_addr == entry0.rd_addr.
- Issue slot 1: ISS_VALID_1 = (COUNT >= 2) & ~hazard & ISS_READY_0.
  - fire_1 = ISS_VALID_1 & ISS_READY_1.
  - Slot 1 never issues unless slot 0 fires in the same cycle (strict program order).
- Dequeue: n_deq = fire_0 + fire_1; head advances by n_deq.
- Latency: a task enqueued in cycle N is visible on ISS_TASK_x no earlier than cycle N+1.
- Occupancy: COUNT_next = COUNT + n_enq - n_deq.
  - Simultaneous enqueue and dequeue are both honoured.
  - Full (COUNT=DEPTH) and empty (COUNT=0) are distinguished by COUNT, never by pointer equality.
- FLUSH: next-cycle head=0, tail=0, COUNT=0.
  - Overrides any same-cycle enqueue and dequeue; tasks presented in that cycle are dropped.
  - Issue handshakes in the flush cycle still appear on the ports; the consumer is flushed by the same signal.
- Wrap-around: entry index (head+1) and write index (tail+1) are taken modulo DEPTH.
  - Pairs that straddle index DEPTH-1 to 0 behave identically to non-wrapping pairs.

Test Plan:
- Reset then idle -> COUNT=0, ISS_VALID_0=0, ISS_VALID_1=0, ENQ_READY=1; assert RST_N low mid-traffic with COUNT=5 -> same values immediately, without waiting for a clock edge.
- Enqueue pair (ADDI x1 / ADDI x2), ISS_READY_0/1=1 -> next cycle ISS_VALID_0=1 and ISS_VALID_1=1, both fire, COUNT returns to 0.
- Enqueue ADDI x3,x0,5 then ADD x4,x3,x3 -> ISS_VALID_1=0 due to hazard; slot 0 issues the ADDI; next cycle the ADD issues on slot 0.
- With ISS_READY=0, enqueue 4 pairs into DEPTH=8 -> COUNT=8, ENQ_READY=0; a fifth pair offered -> not stored, COUNT stays 8.
- ENQ_VALID_1 only with COUNT=3 -> TASK_1 stored at tail, COUNT=4; enqueue 2 while issuing 2 in the same cycle -> COUNT unchanged.
- Fill and drain 20 alternating pairs through DEPTH=8 so that pointers wrap -> tasks issue in exact enqueue order; assert FLUSH with COUNT=6 plus a pair enqueued in that cycle -> next cycle COUNT=0, ISS_VALID_0=0.

Source files
------------

// File: rtl/issue_queue.sv
// Dual-enqueue, dual-issue in-order task FIFO between decode and execute.
// Task word layout: {rs2_used, rs2_addr[4:0], rs1_used, rs1_addr[4:0], rd_used, rd_addr[4:0], op[13:0]}.
module issue_queue #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          FLUSH,
    input  logic          ENQ_VALID_0,
    input  logic          ENQ_VALID_1,
    input  logic [31:0]   TASK_0,
    input  logic [31:0]   TASK_1,
    output logic          ENQ_READY,
    output logic [31:0]   ISS_TASK_0,
    output logic [31:0]   ISS_TASK_1,
    output logic          ISS_VALID_0,
    output logic          ISS_VALID_1,
    input  logic          ISS_READY_0,
    input  logic          ISS_READY_1,
    output logic [CW-1:0] COUNT
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic       rs2_used;
        logic [4:0] rs2_addr;
        logic       rs1_used;
        logic [4:0] rs1_addr;
        logic       rd_used;
        logic [4:0] rd_addr;
        logic [13:0] op;
    } task_t;

    task_t         mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] head1, tail1;
    logic          hazard;
    logic          fire_0, fire_1;
    logic          enq_ok;
    logic [1:0]    n_enq, n_deq;

    assign head1 = head_q + PW'(1);
    assign tail1 = tail_q + PW'(1);

    assign ISS_TASK_0 = mem_q[head_q];
    assign ISS_TASK_1 = mem_q[head1];

    // Younger head entry reads a register the older one writes (x0 never creates a dependency).
    assign hazard = mem_q[head_q].rd_used && (mem_q[head_q].rd_addr != 5'd0) &&
                    ((mem_q[head1].rs1_used && (mem_q[head1].rs1_addr == mem_q[head_q].rd_addr)) ||
                     (mem_q[head1].rs2_used && (mem_q[head1].rs2_addr == mem_q[head_q].rd_addr)));

    assign ENQ_READY   = (count_q <= CW'(DEPTH - 2));
    assign ISS_VALID_0 = (count_q != '0);
    assign ISS_VALID_1 = (count_q >= CW'(2)) && !hazard && ISS_READY_0;
    assign fire_0      = ISS_VALID_0 && ISS_READY_0;
    assign fire_1      = ISS_VALID_1 && ISS_READY_1;
    assign COUNT       = count_q;

    assign enq_ok = ENQ_READY && !FLUSH;
    assign n_enq  = ENQ_READY ? ({1'b0, ENQ_VALID_0} + {1'b0, ENQ_VALID_1}) : 2'd0;
    assign n_deq  = {1'b0, fire_0} + {1'b0, fire_1};

    always_comb begin
        head_d  = head_q + PW'(n_deq);
        tail_d  = tail_q + PW'(n_enq);
        count_d = count_q + CW'(n_enq) - CW'(n_deq);
        if (FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Compacted write: a lone TASK_1 lands at tail, a pair occupies tail and tail+1.
    always_ff @(posedge CLK) begin
        if (enq_ok && ENQ_VALID_0) begin
            mem_q[tail_q] <= task_t'(TASK_0);
        end
        if (enq_ok && ENQ_VALID_1) begin
            mem_q[ENQ_VALID_0 ? tail1 : tail_q] <= task_t'(TASK_1);
        end
    end

endmodule
